// File: rtl/mult_seq_pkg.sv
// Shared constants for the p18240 multiplier coprocessor: ALU opcodes,
// sequencer states and datapath widths.
package mult_seq_pkg;

   localparam int OP_W   = 16;
   localparam int PROD_W = 32;

   typedef enum logic [1:0] {
      F_A           = 2'd0,
      F_A_PLUS_B    = 2'd1,
      F_A_MINUS_B   = 2'd2,
      F_A_MINUS_B_1 = 2'd3
   } alu_op_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      NEGA  = 3'd1,
      NEGB  = 3'd2,
      RUN   = 3'd3,
      FIXLO = 3'd4,
      FIXHI = 3'd5,
      DONE  = 3'd6
   } mult_state_t;

endpackage

// File: rtl/mult_seq_alu.sv
// 16-bit ALU slice; c is carry-out for addition and borrow-out for subtraction.
module alu
   import mult_seq_pkg::*;
(
   input  logic [OP_W-1:0] a,
   input  logic [OP_W-1:0] b,
   input  alu_op_t         op,
   output logic [OP_W-1:0] f,
   output logic            c
);

   logic [OP_W:0] r;

   always_comb begin
      r = {1'b0, a};
      unique case (op)
         F_A:           r = {1'b0, a};
         F_A_PLUS_B:    r = {1'b0, a} + {1'b0, b};
         F_A_MINUS_B:   r = {1'b0, a} - {1'b0, b};
         F_A_MINUS_B_1: r = {1'b0, a} - {1'b0, b} - 17'd1;
         default:       r = {1'b0, a};
      endcase
   end

   assign f = r[OP_W-1:0];
   assign c = r[OP_W];

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle 16x16->32 sign-magnitude multiplier sequencer driving one ALU:
// negate operands, 16-step shift-add, then 32-bit negate of the result.
module mult_seq
   import mult_seq_pkg::*;
(
   input  logic              clock,
   input  logic              reset_L,
   input  logic              start,
   input  logic              is_signed,
   input  logic [OP_W-1:0]   opA,
   input  logic [OP_W-1:0]   opB,
   output logic              ready,
   output logic              done,
   output logic [PROD_W-1:0] product,
   output logic              product_zero
);

   mult_state_t     state;
   logic [OP_W-1:0] mcand;
   logic [OP_W-1:0] hi;
   logic [OP_W-1:0] lo;
   logic            sgn;
   logic            neg;
   logic            borrow;
   logic [3:0]      cnt;

   logic [OP_W-1:0] alu_a;
   logic [OP_W-1:0] alu_b;
   alu_op_t         alu_op;
   logic [OP_W-1:0] alu_f;
   logic            alu_c;

   alu u_alu (
      .a  (alu_a),
      .b  (alu_b),
      .op (alu_op),
      .f  (alu_f),
      .c  (alu_c)
   );

   // When no operation is needed the register is routed through F_A so every
   // state can load the ALU result unconditionally.
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = F_A;
      unique case (state)
         NEGA: begin
            if (sgn && mcand[OP_W-1]) begin
               alu_b  = mcand;
               alu_op = F_A_MINUS_B;
            end else begin
               alu_a = mcand;
            end
         end
         NEGB: begin
            if (sgn && lo[OP_W-1]) begin
               alu_b  = lo;
               alu_op = F_A_MINUS_B;
            end else begin
               alu_a = lo;
            end
         end
         RUN: begin
            alu_a  = hi;
            alu_b  = mcand;
            alu_op = lo[0] ? F_A_PLUS_B : F_A;
         end
         FIXLO: begin
            if (neg) begin
               alu_b  = lo;
               alu_op = F_A_MINUS_B;
            end else begin
               alu_a = lo;
            end
         end
         FIXHI: begin
            if (neg) begin
               alu_b  = hi;
               alu_op = borrow ? F_A_MINUS_B_1 : F_A_MINUS_B;
            end else begin
               alu_a = hi;
            end
         end
         default: begin
            alu_a  = '0;
            alu_b  = '0;
            alu_op = F_A;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state  <= IDLE;
         mcand  <= '0;
         hi     <= '0;
         lo     <= '0;
         sgn    <= 1'b0;
         neg    <= 1'b0;
         borrow <= 1'b0;
         cnt    <= '0;
         ready  <= 1'b1;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  sgn    <= is_signed;
                  neg    <= is_signed & (opA[OP_W-1] ^ opB[OP_W-1]);
                  mcand  <= opA;
                  lo     <= opB;
                  hi     <= '0;
                  borrow <= 1'b0;
                  ready  <= 1'b0;
                  state  <= NEGA;
               end
            end
            NEGA: begin
               mcand <= alu_f;
               state <= NEGB;
            end
            NEGB: begin
               lo    <= alu_f;
               cnt   <= '0;
               state <= RUN;
            end
            RUN: begin
               hi  <= {alu_c, alu_f[OP_W-1:1]};
               lo  <= {alu_f[0], lo[OP_W-1:1]};
               cnt <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  state <= FIXLO;
               end
            end
            FIXLO: begin
               lo     <= alu_f;
               borrow <= alu_c;
               state  <= FIXHI;
            end
            FIXHI: begin
               hi    <= alu_f;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

   assign product      = {hi, lo};
   assign product_zero = (product == '0);

endmodule

// File: tb/tb_mult_seq.sv
// Randomised and directed bench for mult_seq against an arithmetic product model.
module tb_mult_seq;

   logic        clock;
   logic        reset_L;
   logic        start;
   logic        is_signed;
   logic [15:0] opA;
   logic [15:0] opB;
   logic        ready;
   logic        done;
   logic [31:0] product;
   logic        product_zero;

   int errors = 0;
   int checks = 0;

   mult_seq dut (
      .clock        (clock),
      .reset_L      (reset_L),
      .start        (start),
      .is_signed    (is_signed),
      .opA          (opA),
      .opB          (opB),
      .ready        (ready),
      .done         (done),
      .product      (product),
      .product_zero (product_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic s, input logic [15:0] a, input logic [15:0] b);
      longint x;
      longint y;
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      return 32'(x * y);
   endfunction

   // Called away from the clock edge with the DUT idle. Start is sampled at the
   // next edge (cycle t); done must appear in cycle t+21 and ready in t+22.
   task automatic do_op(input logic s, input logic [15:0] a, input logic [15:0] b, input bit poke);
      logic [31:0] exp;
      logic [31:0] done_prod;
      int done_at;
      int ready_at;
      int pulses;
      exp       = ref_mul(s, a, b);
      done_at   = 0;
      ready_at  = 0;
      pulses    = 0;
      done_prod = 'x;
      start     = 1'b1;
      is_signed = s;
      opA       = a;
      opB       = b;
      @(posedge clock);
      #1;
      start     = 1'b0;
      is_signed = 1'($urandom);
      opA       = 16'($urandom);
      opB       = 16'($urandom);
      check("busy_ready", {31'd0, ready}, 32'd0);
      for (int k = 1; k <= 30; k++) begin
         if (poke && k == 4) begin
            start     = 1'b1;
            is_signed = ~s;
            opA       = ~a;
            opB       = b + 16'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clock);
         #1;
         if (done) begin
            pulses++;
            if (done_at == 0) begin
               done_at   = k + 1;
               done_prod = product;
            end
         end
         if (ready) begin
            ready_at = k + 1;
            break;
         end
      end
      check("done_cycle", done_at, 32'd21);
      check("ready_cycle", ready_at, 32'd22);
      check("done_pulses", pulses, 32'd1);
      check("product_at_done", done_prod, exp);
      check("product_idle", product, exp);
      check("product_zero", {31'd0, product_zero}, {31'd0, (exp == 32'd0)});
      $display("op s=%0d %h x %h -> %h (expect %h) done@t+%0d ready@t+%0d",
               s, a, b, product, exp, done_at, ready_at);
   endtask

   typedef struct {
      logic        s;
      logic [15:0] a;
      logic [15:0] b;
   } vec_t;

   vec_t dir[$];

   initial begin
      reset_L   = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      opA       = '0;
      opB       = '0;
      #12;
      check("reset_ready", {31'd0, ready}, 32'd1);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_product", product, 32'd0);
      check("reset_pzero", {31'd0, product_zero}, 32'd1);
      @(negedge clock);
      reset_L = 1'b1;

      dir.push_back('{1'b0, 16'h0003, 16'h0005});
      dir.push_back('{1'b0, 16'hFFFF, 16'hFFFF});
      dir.push_back('{1'b1, 16'hFFFF, 16'hFFFF});
      dir.push_back('{1'b1, 16'hFFFD, 16'h0005});
      dir.push_back('{1'b1, 16'h8000, 16'h8000});
      dir.push_back('{1'b1, 16'h8000, 16'h0001});
      dir.push_back('{1'b0, 16'h1234, 16'h0000});
      dir.push_back('{1'b1, 16'h0000, 16'hFFFF});
      dir.push_back('{1'b1, 16'h0005, 16'hFFFD});
      foreach (dir[i]) do_op(dir[i].s, dir[i].a, dir[i].b, 1'b0);

      // Spot-check the literal expectations independent of the model.
      do_op(1'b1, 16'hFFFD, 16'h0005, 1'b0);
      check("lit_m3x5", product, 32'hFFFFFFF1);
      do_op(1'b1, 16'h8000, 16'h0001, 1'b0);
      check("lit_8000x1", product, 32'hFFFF8000);

      // A start pulse mid-operation must be ignored.
      do_op(1'b0, 16'h0003, 16'h0005, 1'b1);
      check("poke_result", product, 32'h0000000F);

      for (int i = 0; i < 20; i++) begin
         do_op(1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      end

      // Reset in the middle of RUN abandons the operation.
      begin
         int pulses;
         pulses    = 0;
         start     = 1'b1;
         is_signed = 1'b0;
         opA       = 16'h00FF;
         opB       = 16'h0101;
         @(posedge clock);
         #1;
         start = 1'b0;
         for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            if (done) pulses++;
         end
         reset_L = 1'b0;
         #1;
         check("abort_ready", {31'd0, ready}, 32'd1);
         check("abort_done", {31'd0, done}, 32'd0);
         check("abort_product", product, 32'd0);
         check("abort_no_pulse", pulses, 32'd0);
         @(negedge clock);
         reset_L = 1'b1;
         do_op(1'b0, 16'd7, 16'd6, 1'b0);
         check("post_reset_7x6", product, 32'h0000002A);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
